// File: rtl/saida_pkg.sv
// Shared types and seven-segment encodings for the decimal display sequencer.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package saida_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_decod.sv
// One BCD digit to active-low seven-segment code, with a forced-blank input.
module bcd_seg_decod
    import saida_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : digit_to_seg(digit);
    end

endmodule

// File: rtl/saida_display_seq.sv
// Serial double-dabble binary-to-decimal converter driving N_DIG digits plus a
// sign digit and a LED mirror; one conversion step per clock.
module saida_display_seq
    import saida_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_DIG  = 3,
    parameter int unsigned LED_W  = 11,
    parameter int unsigned LZB    = 1
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        Dado,
    input  logic                     OutWrite,
    input  logic                     Signed,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Overflow,
    output logic [7*(N_DIG+1)-1:0]   Displays,
    output logic [LED_W-1:0]         LEDs
);

    localparam int unsigned BCD_W = 4 * N_DIG;
    localparam int unsigned DISP_W = 7 * (N_DIG + 1);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    state_t state_q = IDLE;
    state_t state_d;

    logic [DATA_W-1:0] mag_q  = '0;
    logic [BCD_W-1:0]  bcd_q  = '0;
    logic [CNT_W-1:0]  cnt_q  = '0;
    logic              ovf_q  = 1'b0;
    logic              neg_q  = 1'b0;
    logic [LED_W-1:0]  led_q  = '0;

    logic [DISP_W-1:0] disp_q = '1;
    logic [LED_W-1:0]  leds_q = '0;
    logic              ovf_out_q = 1'b0;
    logic              done_q = 1'b0;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_step;
    logic              step_carry;
    logic              in_neg;
    logic [N_DIG-1:0]  blank;
    logic              nz_above;
    logic [6:0]        seg [N_DIG];
    logic [DISP_W-1:0] disp_d;

    assign Busy     = (state_q != IDLE);
    assign Done     = done_q;
    assign Overflow = ovf_out_q;
    assign Displays = disp_q;
    assign LEDs     = leds_q;
    assign in_neg   = Signed && Dado[DATA_W-1];

    always_ff @(posedge CLK) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (OutWrite) state_d = CONV;
            CONV:    if (cnt_q == LAST_STEP) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction then shift; the bit leaving the top digit means the
    // magnitude has reached 10**N_DIG.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {step_carry, bcd_step} = {bcd_adj, mag_q[DATA_W-1]};
    end

    // Leading-zero blanking walks from the top digit down; units never blank.
    always_comb begin
        nz_above = 1'b0;
        blank    = '0;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            nz_above = nz_above | (bcd_q[4*(N_DIG-1-i) +: 4] != 4'd0);
            blank[N_DIG-1-i] = (LZB != 0) && ((N_DIG - 1 - i) != 0) && !nz_above;
        end
    end

    for (genvar g = 0; g < N_DIG; g++) begin : g_dig
        bcd_seg_decod u_dec (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg[g])
        );
    end

    always_comb begin
        disp_d = '1;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            disp_d[7*i +: 7] = ovf_q ? SEG_E : seg[i];
        end
        disp_d[7*N_DIG +: 7] = neg_q ? SEG_DASH : SEG_BLANK;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mag_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            led_q     <= '0;
            disp_q    <= '1;
            leds_q    <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (OutWrite) begin
                        mag_q <= in_neg ? -Dado : Dado;
                        neg_q <= in_neg;
                        led_q <= Dado[LED_W-1:0];
                        bcd_q <= '0;
                        ovf_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_step;
                    mag_q <= {mag_q[DATA_W-2:0], 1'b0};
                    ovf_q <= ovf_q | step_carry;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                LOAD: begin
                    disp_q    <= disp_d;
                    leds_q    <= led_q;
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_saida_display_seq.sv
// Scoreboard bench for saida_display_seq at default parameters.
module tb_saida_display_seq;

    localparam int N_DIG  = 3;
    localparam int DATA_W = 32;
    localparam int LED_W  = 11;
    localparam int DISP_W = 7 * (N_DIG + 1);

    typedef struct packed {
        logic [DISP_W-1:0] disp;
        logic [LED_W-1:0]  leds;
        logic              ovf;
    } exp_t;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic [DATA_W-1:0] Dado = '0;
    logic              OutWrite = 1'b0;
    logic              Signed = 1'b0;
    logic              Busy, Done, Overflow;
    logic [DISP_W-1:0] Displays;
    logic [LED_W-1:0]  LEDs;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    saida_display_seq #(.DATA_W(DATA_W), .N_DIG(N_DIG), .LED_W(LED_W), .LZB(1)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Dado     (Dado),
        .OutWrite (OutWrite),
        .Signed   (Signed),
        .Busy     (Busy),
        .Done     (Done),
        .Overflow (Overflow),
        .Displays (Displays),
        .LEDs     (LEDs)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [DATA_W-1:0] d, input bit s);
        exp_t e;
        longint mag, p, lim;
        bit neg;
        neg = s && d[DATA_W-1];
        mag = neg ? ((longint'(1) << DATA_W) - longint'(d)) : longint'(d);
        lim = 1;
        for (int i = 0; i < N_DIG; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        p = 1;
        for (int i = 0; i < N_DIG; i++) begin
            logic [6:0] sg;
            if (e.ovf)                sg = 7'b0000110;
            else if (i > 0 && mag < p) sg = 7'b1111111;
            else                      sg = seg_tbl[int'((mag / p) % 10)];
            e.disp[7*i +: 7] = sg;
            p = p * 10;
        end
        e.disp[7*N_DIG +: 7] = neg ? 7'b0111111 : 7'b1111111;
        e.leds = d[LED_W-1:0];
        return e;
    endfunction

    // Called at a negedge; the request is sampled by the following posedge.
    task automatic send(input logic [DATA_W-1:0] d, input bit s);
        Dado = d;
        Signed = s;
        OutWrite = 1'b1;
        sb.push_back(model(d, s));
        @(negedge CLK);
        OutWrite = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int busy_n = 0;
        bit seen = 1'b0;
        exp_t e;
        for (int c = 0; c < 200; c++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_n++;
            @(negedge CLK);
        end
        check_eq({tag, "_done"}, 64'(seen), 64'd1);
        if (seen) begin
            check_eq({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
            if (sb.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                check_eq({tag, "_disp"}, 64'(Displays), 64'(e.disp));
                check_eq({tag, "_leds"}, 64'(LEDs), 64'(e.leds));
                check_eq({tag, "_ovf"}, 64'(Overflow), 64'(e.ovf));
            end
        end
    endtask

    logic [DATA_W-1:0] vec_d [8] = '{32'hFFFFFFFB, 32'd1000, 32'hFFFFFFFB, 32'd0,
                                     32'h80000000, 32'd999, 32'hFFFFFC19, 32'd100};
    bit vec_s [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int done_cnt;
        logic [DATA_W-1:0] rd;
        bit rs;

        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        check_eq("rst_disp", 64'(Displays), 64'({DISP_W{1'b1}}));
        check_eq("rst_leds", 64'(LEDs), 64'd0);
        check_eq("rst_ovf", 64'(Overflow), 64'd0);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);

        @(negedge CLK);
        send(32'd123, 1'b0);
        wait_done("dec123", DATA_W + 1);
        @(negedge CLK);
        check_eq("done_pulse", 64'(Done), 64'd0);
        repeat (3) @(negedge CLK);
        check_eq("hold_disp", 64'(Displays), 64'(last_exp.disp));

        // Each request is issued in the Done cycle of the previous one.
        send(vec_d[0], vec_s[0]);
        for (int i = 0; i < 8; i++) begin
            wait_done($sformatf("vec%0d", i), DATA_W + 1);
            if (i < 7) send(vec_d[i+1], vec_s[i+1]);
        end

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            rd = 32'($urandom_range(0, 2000));
            rs = 1'($urandom_range(0, 1));
            if (rs && (i % 2 == 0)) rd = -rd;
            send(rd, rs);
            wait_done($sformatf("rnd%0d", i), DATA_W + 1);
        end

        @(negedge CLK);
        send(32'd555, 1'b0);
        repeat (4) @(negedge CLK);
        Dado = 32'd7;
        OutWrite = 1'b1;
        @(negedge CLK);
        OutWrite = 1'b0;
        wait_done("ignore", DATA_W + 1 - 5);

        @(negedge CLK);
        send(32'd888, 1'b0);
        repeat (9) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        sb.delete();
        check_eq("abort_busy", 64'(Busy), 64'd0);
        check_eq("abort_disp", 64'(Displays), 64'({DISP_W{1'b1}}));
        check_eq("abort_leds", 64'(LEDs), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (Done) done_cnt++;
            @(negedge CLK);
        end
        check_eq("abort_nodone", 64'(done_cnt), 64'd0);

        send(32'd42, 1'b0);
        wait_done("dec42", DATA_W + 1);

        @(negedge CLK);
        Reset = 1'b1;
        OutWrite = 1'b1;
        Dado = 32'd5;
        @(negedge CLK);
        Reset = 1'b0;
        OutWrite = 1'b0;
        check_eq("rst_wins_busy", 64'(Busy), 64'd0);
        check_eq("rst_wins_disp", 64'(Displays), 64'({DISP_W{1'b1}}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
